// File: rtl/led_sched_pkg.sv
// Register map, pattern mode encoding and STATUS bit layout shared by the
// LED scheduler controller.
package led_sched_pkg;

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_MODE   = 2'd1;
    localparam logic [1:0] ADDR_PERIOD = 2'd2;
    localparam logic [1:0] ADDR_STATUS = 2'd3;

    typedef enum logic [1:0] {
        MODE_STATIC = 2'd0,
        MODE_BLINK  = 2'd1,
        MODE_CHASE  = 2'd2,
        MODE_MIRROR = 2'd3
    } mode_e;

    localparam int STAT_MODE_LSB    = 4;
    localparam int STAT_PAUSED      = 6;
    localparam int STAT_KEY_EVENT   = 8;
    localparam int STAT_KEY_DROPPED = 9;

    function automatic logic [31:0] status_word(
        input logic [3:0] led,
        input mode_e      mode,
        input logic       paused,
        input logic       key_event,
        input logic       key_dropped
    );
        logic [31:0] w;
        w = '0;
        w[3:0]                  = led;
        w[STAT_MODE_LSB +: 2]   = mode;
        w[STAT_PAUSED]          = paused;
        w[STAT_KEY_EVENT]       = key_event;
        w[STAT_KEY_DROPPED]     = key_dropped;
        return w;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// One push-button: 2-FF synchronizer, stability counter and a single-cycle
// press pulse on an accepted released->pressed transition (key is active-low).
module key_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic level,
    output logic press
);

    localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync_1;
    logic          sync_2;
    logic          sync_prev;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_1    <= 1'b1;
            sync_2    <= 1'b1;
            sync_prev <= 1'b1;
            cnt       <= '0;
            level     <= 1'b1;
            press     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments let every flop sample pre-edge values, so the sync chain really is two stages.
            sync_1    <= key_n;
            sync_2    <= sync_1;
            sync_prev <= sync_2;
            press     <= 1'b0;
            // Count only while the synced level is steady and differs from the accepted one.
            if ((sync_2 != sync_prev) || (sync_2 == level)) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                cnt   <= '0;
                level <= sync_2;
                press <= ~sync_2;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/led_sched_ctrl.sv
// Avalon-MM LED pattern controller: DATA/MODE/PERIOD/STATUS registers, tick
// generator, and arbitration between bus writes and debounced KEY[2:0] actions.
module led_sched_ctrl
    import led_sched_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter logic [31:0] PERIOD_RESET    = 32'd25000000
) (
    input  logic        clk_clk,
    input  logic        reset_reset_n,
    input  logic [1:0]  avs_address,
    input  logic        avs_write,
    input  logic [31:0] avs_writedata,
    input  logic        avs_read,
    output logic [31:0] avs_readdata,
    input  logic [2:0]  key_n,
    output logic [3:0]  led
);

    logic [2:0] key_level;
    logic [2:0] key_press;

    for (genvar i = 0; i < 3; i++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_key (
            .clk   (clk_clk),
            .rst_n (reset_reset_n),
            .key_n (key_n[i]),
            .level (key_level[i]),
            .press (key_press[i])
        );
    end

    logic [3:0]  data_q;
    mode_e       mode_q;
    logic [31:0] period_q;
    logic [31:0] tick_cnt_q;
    logic        paused_q;
    logic        key_event_q;
    logic        key_dropped_q;
    logic        phase_q;
    logic [3:0]  chase_q;

    logic wr_data, wr_mode, wr_period, wr_status;
    assign wr_data   = avs_write && (avs_address == ADDR_DATA);
    assign wr_mode   = avs_write && (avs_address == ADDR_MODE);
    assign wr_period = avs_write && (avs_address == ADDR_PERIOD);
    assign wr_status = avs_write && (avs_address == ADDR_STATUS);

    // A bus write to the same register beats the key action in that cycle.
    logic key0_take, key1_take, key_event_set, key_dropped_set;
    assign key0_take       = key_press[0] && !wr_mode;
    assign key1_take       = key_press[1] && !wr_data;
    assign key_event_set   = key0_take || key1_take || key_press[2];
    assign key_dropped_set = (key_press[0] && wr_mode) || (key_press[1] && wr_data);

    logic [3:0]  data_d;
    mode_e       mode_d;
    logic [3:0]  led_d;
    logic [31:0] read_word;
    logic        mode_change;
    logic        tick;

    always_comb begin
        // NOTE: every output of this block is defaulted first so no path can infer a latch.
        data_d    = data_q;
        mode_d    = mode_q;
        led_d     = data_q;
        read_word = '0;

        if (wr_data)        data_d = avs_writedata[3:0];
        else if (key1_take) data_d = ~data_q;

        if (wr_mode)        mode_d = mode_e'(avs_writedata[1:0]);
        else if (key0_take) mode_d = mode_e'(mode_q + 2'd1);

        case (mode_q)
            MODE_STATIC: led_d = data_q;
            MODE_BLINK:  led_d = phase_q ? 4'b0000 : data_q;
            MODE_CHASE:  led_d = chase_q;
            MODE_MIRROR: led_d = {1'b0, ~key_level};
            default:     led_d = data_q;
        endcase

        case (avs_address)
            ADDR_DATA:   read_word = {28'b0, data_q};
            ADDR_MODE:   read_word = {30'b0, mode_q};
            ADDR_PERIOD: read_word = period_q;
            ADDR_STATUS: read_word = status_word(led, mode_q, paused_q, key_event_q, key_dropped_q);
            default:     read_word = '0;
        endcase
    end

    assign mode_change = (mode_d != mode_q);
    assign tick        = !paused_q && (tick_cnt_q == period_q - 32'd1);

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            data_q        <= 4'b0000;
            mode_q        <= MODE_STATIC;
            period_q      <= PERIOD_RESET;
            tick_cnt_q    <= '0;
            paused_q      <= 1'b0;
            key_event_q   <= 1'b0;
            key_dropped_q <= 1'b0;
            phase_q       <= 1'b0;
            chase_q       <= 4'b0001;
            led           <= 4'b0000;
            avs_readdata  <= '0;
        end else begin
            data_q <= data_d;
            mode_q <= mode_d;
            led    <= led_d;

            // Reads sample pre-write state, so read+write to one address returns the old value.
            if (avs_read)    avs_readdata <= read_word;
            if (wr_period)   period_q     <= (avs_writedata == 32'd0) ? 32'd1 : avs_writedata;
            if (key_press[2]) paused_q    <= ~paused_q;

            if (key_event_set)
                key_event_q <= 1'b1;
            else if (wr_status && avs_writedata[STAT_KEY_EVENT])
                key_event_q <= 1'b0;

            if (key_dropped_set)
                key_dropped_q <= 1'b1;
            else if (wr_status && avs_writedata[STAT_KEY_DROPPED])
                key_dropped_q <= 1'b0;

            if (mode_change || wr_period)
                tick_cnt_q <= '0;
            else if (!paused_q)
                tick_cnt_q <= tick ? '0 : tick_cnt_q + 32'd1;

            if (mode_change) begin
                phase_q <= 1'b0;
                chase_q <= 4'b0001;
            end else if (tick) begin
                if (mode_q == MODE_BLINK) phase_q <= ~phase_q;
                if (mode_q == MODE_CHASE) chase_q <= {chase_q[2:0], chase_q[3]};
            end
        end
    end

endmodule

// File: tb/tb_led_sched_ctrl.sv
// Scoreboard bench for led_sched_ctrl: a rule-level model predicts read data
// and LED output each cycle; a monitor compares on the falling clock edge.
module tb_led_sched_ctrl;
    import led_sched_pkg::*;

    localparam int unsigned DEB  = 4;
    localparam logic [31:0] PRST = 32'd8;

    logic        clk_clk = 1'b0;
    logic        reset_reset_n;
    logic [1:0]  avs_address;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic        avs_read;
    logic [31:0] avs_readdata;
    logic [2:0]  key_n;
    logic [3:0]  led;

    always #5 clk_clk = ~clk_clk;

    led_sched_ctrl #(
        .DEBOUNCE_CYCLES(DEB),
        .PERIOD_RESET   (PRST)
    ) dut (
        .clk_clk       (clk_clk),
        .reset_reset_n (reset_reset_n),
        .avs_address   (avs_address),
        .avs_write     (avs_write),
        .avs_writedata (avs_writedata),
        .avs_read      (avs_read),
        .avs_readdata  (avs_readdata),
        .key_n         (key_n),
        .led           (led)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model state, in rule terms: chase is an index, phase a parity.
    logic [3:0]  m_data;
    int          m_mode;
    logic [31:0] m_period;
    bit          m_paused, m_event, m_drop, m_phase;
    longint      m_cnt;
    int          m_chase_idx;
    logic [2:0]  m_keys;
    logic [3:0]  m_led;
    logic [31:0] rd_q[$];
    bit          rd_due;
    bit          led_chk_en;

    function automatic logic [3:0] m_pattern();
        case (m_mode)
            0:       return m_data;
            1:       return m_phase ? 4'h0 : m_data;
            2:       return 4'(1 << m_chase_idx);
            default: return {1'b0, ~m_keys};
        endcase
    endfunction

    function automatic logic [31:0] m_read(input logic [1:0] a);
        case (a)
            2'd0:    return {28'h0, m_data};
            2'd1:    return 32'(m_mode);
            2'd2:    return m_period;
            default: return {22'h0, m_drop, m_event, 1'b0, m_paused, 2'(m_mode), m_led};
        endcase
    endfunction

    task automatic m_reset();
        m_data = 4'h0; m_mode = 0; m_period = PRST;
        m_paused = 0; m_event = 0; m_drop = 0; m_phase = 0;
        m_cnt = 0; m_chase_idx = 0; m_led = 4'h0;
        rd_q.delete(); rd_due = 0;
    endtask

    always @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            m_reset();
        end else begin
            bit m_tick;
            int new_mode;
            rd_due = avs_read;
            if (avs_read) rd_q.push_back(m_read(avs_address));
            m_led    = m_pattern();
            m_tick   = !m_paused && (m_cnt == longint'(m_period) - 1);
            new_mode = m_mode;
            if (avs_write) begin
                case (avs_address)
                    2'd0: m_data = avs_writedata[3:0];
                    2'd1: new_mode = int'(avs_writedata[1:0]);
                    2'd2: m_period = (avs_writedata == 32'd0) ? 32'd1 : avs_writedata;
                    default: begin
                        if (avs_writedata[8]) m_event = 0;
                        if (avs_writedata[9]) m_drop  = 0;
                    end
                endcase
            end
            if (new_mode != m_mode) begin
                m_mode = new_mode; m_cnt = 0; m_phase = 0; m_chase_idx = 0;
            end else begin
                if (m_tick && m_mode == 1) m_phase = !m_phase;
                if (m_tick && m_mode == 2) m_chase_idx = (m_chase_idx + 1) % 4;
                if (avs_write && avs_address == 2'd2) m_cnt = 0;
                else if (!m_paused) m_cnt = m_tick ? 0 : m_cnt + 1;
            end
        end
    end

    // Monitor: read data is due one cycle after the read; LED every cycle.
    always @(negedge clk_clk) begin
        if (reset_reset_n) begin
            if (rd_due) begin
                if (rd_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL readdata: got 0x%0h, expected nothing queued", avs_readdata);
                end else begin
                    check("readdata", avs_readdata, rd_q.pop_front());
                end
            end
            if (led_chk_en) check("led", {28'h0, led}, {28'h0, m_led});
        end
    end

    task automatic bus(input bit w, input bit r, input logic [1:0] a, input logic [31:0] d);
        @(negedge clk_clk);
        avs_write = w; avs_read = r; avs_address = a; avs_writedata = d;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) bus(1'b0, 1'b0, 2'd0, 32'd0);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d); bus(1'b1, 1'b0, a, d); endtask
    task automatic rd(input logic [1:0] a); bus(1'b0, 1'b1, a, 32'd0); endtask

    // Clears the tick counter in both DUT and model after a key window.
    task automatic resync(input logic [31:0] p);
        wr(ADDR_PERIOD, p);
        idle(2);
        led_chk_en = 1;
    endtask

    // Bouncy press (2-cycle glitches) then a stable low; optionally hammers MODE=3 writes.
    task automatic key_press(input int k, input bit collide);
        led_chk_en = 0;
        for (int i = 0; i < 22; i++) begin
            if (collide) wr(ADDR_MODE, 32'd3); else idle(1);
            key_n[k] = (i < 8) ? 1'((i / 2) % 2) : 1'b0;
        end
        idle(1);
    endtask

    task automatic key_release(input int k);
        led_chk_en = 0;
        for (int i = 0; i < 22; i++) begin
            idle(1);
            key_n[k] = (i < 8) ? 1'(((i / 2) % 2) == 0) : 1'b1;
        end
        idle(1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: run did not finish, %0d checks done", n_checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_reset_n = 1'b0;
        avs_address = 2'd0; avs_write = 1'b0; avs_writedata = 32'd0; avs_read = 1'b0;
        key_n = 3'b111; m_keys = 3'b111; led_chk_en = 0;
        repeat (3) @(negedge clk_clk);
        check("reset_led", {28'h0, led}, 32'h0);
        check("reset_readdata", avs_readdata, 32'h0);
        reset_reset_n = 1'b1;
        led_chk_en = 1;

        rd(ADDR_DATA); rd(ADDR_MODE); rd(ADDR_PERIOD); rd(ADDR_STATUS);
        idle(2);

        // Blink at PERIOD 8, then PERIOD 0 (stores 1)
        wr(ADDR_DATA, 32'hA); wr(ADDR_MODE, 32'd1);
        idle(40);
        wr(ADDR_PERIOD, 32'd0); rd(ADDR_PERIOD);
        idle(10);

        // Chase
        wr(ADDR_MODE, 32'd2); wr(ADDR_PERIOD, 32'd8);
        idle(40);

        // Pause and resume
        wr(ADDR_PERIOD, 32'd500);
        key_press(2, 0); key_release(2);
        m_paused = 1; m_event = 1;
        resync(32'd8);
        rd(ADDR_STATUS);
        idle(40);
        wr(ADDR_PERIOD, 32'd500);
        key_press(2, 0); key_release(2);
        m_paused = 0;
        resync(32'd8);
        idle(40);
        wr(ADDR_STATUS, 32'h100); rd(ADDR_STATUS);

        // Bouncy key0 press: one mode increment
        wr(ADDR_PERIOD, 32'd500);
        key_press(0, 0); key_release(0);
        m_mode = (m_mode + 1) % 4; m_phase = 0; m_chase_idx = 0; m_cnt = 0; m_event = 1;
        resync(32'd8);
        rd(ADDR_MODE); rd(ADDR_STATUS);
        wr(ADDR_STATUS, 32'h100); rd(ADDR_STATUS);
        idle(2);

        // key0 event colliding with a bus MODE write
        wr(ADDR_MODE, 32'd0); wr(ADDR_PERIOD, 32'd500);
        key_press(0, 1); key_release(0);
        m_drop = 1;
        resync(32'd8);
        rd(ADDR_MODE); rd(ADDR_STATUS);
        idle(2);

        // Hold key1 in mirror mode
        key_press(1, 0);
        m_data = ~m_data; m_event = 1; m_keys[1] = 1'b0;
        resync(32'd8);
        idle(10);
        check("mirror_led1", {31'h0, led[1]}, 32'd1);
        rd(ADDR_DATA); rd(ADDR_STATUS);
        key_release(1);
        m_keys = 3'b111;
        resync(32'd8);
        idle(4);

        // Randomized bus traffic
        for (int i = 0; i < 600; i++) begin
            int r;
            logic [1:0] a;
            logic [31:0] d;
            r = int'($urandom_range(0, 99));
            a = 2'($urandom_range(0, 3));
            case (a)
                2'd2:    d = $urandom_range(0, 12);
                2'd3:    d = $urandom;
                default: d = $urandom_range(0, 15);
            endcase
            bus(r < 15, (r >= 10) && (r < 45), a, d);
        end
        idle(3);

        // Reset mid-chase with a key debounce in flight
        wr(ADDR_MODE, 32'd2); wr(ADDR_PERIOD, 32'd8);
        idle(13);
        rd(ADDR_PERIOD);
        idle(1);
        key_n[0] = 1'b0;
        idle(3);
        led_chk_en = 0;
        #3 reset_reset_n = 1'b0;
        #1;
        check("async_reset_led", {28'h0, led}, 32'h0);
        check("async_reset_readdata", avs_readdata, 32'h0);
        @(negedge clk_clk);
        key_n = 3'b111;
        repeat (2) @(negedge clk_clk);
        reset_reset_n = 1'b1;
        m_keys = 3'b111;
        led_chk_en = 1;
        check("post_reset_readdata", avs_readdata, 32'h0);
        rd(ADDR_DATA); rd(ADDR_MODE); rd(ADDR_PERIOD); rd(ADDR_STATUS);
        idle(30);
        rd(ADDR_STATUS);
        idle(3);
        check("rd_queue_drained", 32'(rd_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
